// File: rtl/lfsr5_pkg.sv
// Shared definitions for the 5-bit Fibonacci PRBS generator/checker pair.
// Taps [4]^[1]; the newest bit enters at bit 0, giving a period of 31.
package lfsr5_pkg;

  localparam int LFSR_W = 5;
  localparam int TAP_HI = 4;
  localparam int TAP_LO = 1;

  typedef enum logic {
    SEED  = 1'b0,
    CHECK = 1'b1
  } state_e;

  function automatic logic lfsr5_fb(input logic [LFSR_W-1:0] s);
    return s[TAP_HI] ^ s[TAP_LO];
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr5_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], lfsr5_fb(s)};
  endfunction

endpackage

// File: rtl/lfsr5_win_monitor.sv
// Error-burst monitor: counts errors per WINDOW valid checked bits and raises
// a combinational loss strobe when the window total reaches LOSS_THRESH.
module lfsr5_win_monitor #(
  parameter int WINDOW      = 31,
  parameter int LOSS_THRESH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic err,
  output logic loss
);

  localparam int CW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(LOSS_THRESH + 1);

  logic [CW-1:0] win_cnt;
  logic [EW-1:0] win_err;
  logic [EW:0]   err_sum;
  logic          wrap;

  assign wrap    = (win_cnt == CW'(WINDOW - 1));
  assign err_sum = {1'b0, win_err} + {{EW{1'b0}}, err};
  assign loss    = en && (err_sum >= (EW+1)'(LOSS_THRESH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_cnt <= '0;
      win_err <= '0;
    end else if (clr) begin
      win_cnt <= '0;
      win_err <= '0;
    end else if (en) begin
      if (wrap) begin
        // the wrap bit's error opens the next window
        win_cnt <= '0;
        win_err <= EW'(err);
      end else begin
        win_cnt <= win_cnt + CW'(1);
        win_err <= win_err + EW'(err);
      end
    end
  end

endmodule

// File: rtl/lfsr5_prbs_checker.sv
// Self-synchronising receive checker for the 5-bit LFSR stream: seeds from
// five received bits, then flywheels a local LFSR and counts bit errors.
module lfsr5_prbs_checker
  import lfsr5_pkg::*;
#(
  parameter int ERR_CNT_W   = 16,
  parameter int WINDOW      = 31,
  parameter int LOSS_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  input  logic                 din_valid,
  input  logic                 clear_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic                 sync_lost,
  output logic [ERR_CNT_W-1:0] err_count
);

  state_e            state, state_nxt;
  logic [LFSR_W-1:0] sr, sr_nxt, sr_shift;
  logic [2:0]        seed_cnt, seed_cnt_nxt;
  logic              exp_bit, chk_en, err, loss, lock_go;

  assign exp_bit  = lfsr5_fb(sr);
  assign chk_en   = din_valid && (state == CHECK);
  assign err      = chk_en && (din != exp_bit);
  assign sr_shift = {sr[LFSR_W-2:0], din};
  assign locked   = (state == CHECK);

  lfsr5_win_monitor #(
    .WINDOW      (WINDOW),
    .LOSS_THRESH (LOSS_THRESH)
  ) u_win (
    .clk  (clk),
    .rst  (rst),
    .clr  (lock_go),
    .en   (chk_en),
    .err  (err),
    .loss (loss)
  );

  always_comb begin
    state_nxt    = state;
    sr_nxt       = sr;
    seed_cnt_nxt = seed_cnt;
    lock_go      = 1'b0;
    case (state)
      SEED: begin
        if (din_valid) begin
          sr_nxt = sr_shift;
          if (seed_cnt != 3'd5) seed_cnt_nxt = seed_cnt + 3'd1;
          // all-zero register is the LFSR lock-up state, never lock on it
          if (seed_cnt >= 3'd4 && sr_shift != '0) begin
            state_nxt = CHECK;
            lock_go   = 1'b1;
          end
        end
      end
      CHECK: begin
        if (din_valid) begin
          if (loss) begin
            state_nxt    = SEED;
            sr_nxt       = '0;
            seed_cnt_nxt = '0;
          end else begin
            sr_nxt = lfsr5_next(sr);
          end
        end
      end
      default: state_nxt = SEED;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SEED;
      sr        <= '0;
      seed_cnt  <= '0;
      err_pulse <= 1'b0;
      sync_lost <= 1'b0;
    end else begin
      state     <= state_nxt;
      sr        <= sr_nxt;
      seed_cnt  <= seed_cnt_nxt;
      err_pulse <= err;
      sync_lost <= loss;
    end
  end

  // a fresh error takes precedence over a clear in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count <= '0;
    end else if (err) begin
      if (clear_cnt)       err_count <= ERR_CNT_W'(1);
      else if (!(&err_count)) err_count <= err_count + ERR_CNT_W'(1);
    end else if (clear_cnt) begin
      err_count <= '0;
    end
  end

endmodule

// File: tb/tb_lfsr5_prbs_checker.sv
// Directed bench for lfsr5_prbs_checker driven by a behavioural 5-bit generator.
// A 4-bit error counter lets saturation be reached within a short run.
module tb_lfsr5_prbs_checker;
  import lfsr5_pkg::*;

  localparam int ERR_CNT_W = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 din = 1'b0;
  logic                 din_valid = 1'b0;
  logic                 clear_cnt = 1'b0;
  logic                 locked, err_pulse, sync_lost;
  logic [ERR_CNT_W-1:0] err_count;

  int n_chk = 0, n_pass = 0, n_pulse = 0, n_lost = 0;
  int p0, l0, nl;
  logic [LFSR_W-1:0] g = 5'b00001;

  lfsr5_prbs_checker #(
    .ERR_CNT_W   (ERR_CNT_W),
    .WINDOW      (31),
    .LOSS_THRESH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .clear_cnt (clear_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .sync_lost (sync_lost),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_pulse) n_pulse++;
    if (sync_lost) n_lost++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic send(input logic flip, input logic clr = 1'b0);
    g         = lfsr5_next(g);
    din       = g[0] ^ flip;
    din_valid = 1'b1;
    clear_cnt = clr;
    @(posedge clk); #1;
    din_valid = 1'b0;
    clear_cnt = 1'b0;
  endtask

  task automatic idle(input logic clr = 1'b0);
    din_valid = 1'b0;
    din       = 1'($urandom_range(0, 1));
    clear_cnt = clr;
    @(posedge clk); #1;
    clear_cnt = 1'b0;
  endtask

  task automatic pulse_reset();
    din_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_err_pulse"}, err_pulse, 0);
    chk({tag, "_sync_lost"}, sync_lost, 0);
    chk({tag, "_err_count"}, err_count, 0);
  endtask

  initial begin
    // 1: reset, lock on bits 0,1,0,1,1, then 200 clean bits
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    rst = 1'b1;
    repeat (4) send(1'b0);
    chk("t1_prelock", locked, 0);
    send(1'b0);
    chk("t1_lock", locked, 1);
    repeat (195) send(1'b0);
    chk("t1_errcnt", err_count, 0);
    chk("t1_locked", locked, 1);
    chk("t1_pulses", n_pulse, 0);

    // 2: single inverted bit #20 (window position 28)
    p0 = n_pulse;
    for (int i = 1; i <= 20; i++) send(i == 20);
    chk("t2_pulse", err_pulse, 1);
    repeat (10) send(1'b0);
    chk("t2_npulse", n_pulse - p0, 1);
    chk("t2_errcnt", err_count, 1);
    chk("t2_locked", locked, 1);
    idle(1'b1);
    chk("t2_clear", err_count, 0);

    // 3a: four errors at window positions 8..11 force resync
    p0 = n_pulse;
    l0 = n_lost;
    repeat (3) send(1'b1);
    chk("t3_3err_locked", locked, 1);
    send(1'b1);
    chk("t3_sync_lost", sync_lost, 1);
    chk("t3_unlocked", locked, 0);
    chk("t3_errcnt", err_count, 4);
    repeat (4) send(1'b0);
    chk("t3_seeding", locked, 0);
    send(1'b0);
    chk("t3_relock", locked, 1);
    chk("t3_nlost", n_lost - l0, 1);
    chk("t3_npulse", n_pulse - p0, 4);

    // 3b: three errors per window over five windows, then saturation
    idle(1'b1);
    chk("t3b_clear", err_count, 0);
    p0 = n_pulse;
    l0 = n_lost;
    for (int w = 0; w < 5; w++)
      for (int j = 0; j < 31; j++) send(j == 3 || j == 10 || j == 17);
    chk("t3b_errcnt", err_count, 15);
    chk("t3b_locked", locked, 1);
    chk("t3b_nlost", n_lost - l0, 0);
    chk("t3b_npulse", n_pulse - p0, 15);
    for (int j = 0; j < 4; j++) send(j == 3);
    chk("t5_sat_pulse", err_pulse, 1);
    chk("t5_sat_cnt", err_count, 15);

    // 4: constant zero never locks
    pulse_reset();
    chk_zero("t4_rst");
    nl = 0;
    din = 1'b0;
    din_valid = 1'b1;
    repeat (100) begin
      @(posedge clk); #1;
      if (locked) nl++;
    end
    din_valid = 1'b0;
    chk("t4_locked_cycles", nl, 0);
    chk("t4_errcnt", err_count, 0);

    // 5: valid toggling with random din on idle cycles
    pulse_reset();
    p0 = n_pulse;
    for (int i = 0; i < 4; i++) begin send(1'b0); idle(); end
    chk("t5_prelock", locked, 0);
    send(1'b0);
    chk("t5_lock", locked, 1);
    idle();
    for (int i = 0; i < 60; i++) begin send(1'b0); idle(); end
    chk("t5_errcnt0", err_count, 0);
    chk("t5_npulse", n_pulse - p0, 0);
    send(1'b1); idle();
    repeat (3) begin send(1'b0); idle(); end
    send(1'b1); idle();
    chk("t5_errcnt2", err_count, 2);
    send(1'b1, 1'b1);
    chk("t5_clr_err", err_count, 1);
    idle();

    // 6: asynchronous reset mid-CHECK, then relock
    repeat (40) send(1'b0);
    send(1'b1);
    chk("t6_pulse", err_pulse, 1);
    chk("t6_errcnt", err_count, 2);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("t6_async");
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    repeat (4) send(1'b0);
    chk("t6_prelock", locked, 0);
    send(1'b0);
    chk("t6_relock", locked, 1);
    repeat (20) send(1'b0);
    chk("t6_errcnt", err_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
